uc_multiciclo: RTL and testbench

- Control unit feeding the microc datapath. Takes the datapath's Opcode and z flag and drives s_inc, s_inm, s_skip, we3, wez, Op and a PC write enable.
- Replaces per-cycle hand-driven control with a small state machine. Most instructions take 1 cycle. skipeq takes 2 cycles, because its skip decision needs the z flag updated by its own compare.
- Provides halt handling and a retired-instruction counter for debug and verification.

---
 rtl/uc_multiciclo.sv | 120 ++++++++++++
 tb/tb_uc_multiciclo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uc_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : uc_multiciclo
// Brief    : Multicycle control unit for the microc datapath (RUN/SKIP/HALT).
// Revision : 1.0
// ============================================================================
module uc_multiciclo #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             z,
    output logic             s_inc,
    output logic             s_inm,
    output logic             s_skip,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       Op,
    output logic             pc_en,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SKIP = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        s_inc   = 1'b0;
        s_inm   = 1'b0;
        s_skip  = 1'b0;
        we3     = 1'b0;
        wez     = 1'b0;
        Op      = 3'b000;
        pc_en   = 1'b0;
        halted  = 1'b0;
        retire  = 1'b0;
        state_d = state_q;
        count_d = count_q;

        // Reset low forces every output to 0 regardless of state.
        if (!reset) begin
            state_d = ST_RUN;
            count_d = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    s_inc  = 1'b1;
                    pc_en  = 1'b1;
                    retire = 1'b1;
                    case (Opcode[5:3])
                        3'b000: begin
                            Op  = Opcode[2:0];
                            we3 = 1'b1;
                            wez = 1'b1;
                        end
                        3'b001: begin
                            s_inm = 1'b1;
                            we3   = 1'b1;
                        end
                        3'b010: s_inc = 1'b0;
                        3'b011: s_inc = ~z;
                        3'b100: s_inc = z;
                        3'b101: begin
                            // Compare cycle: hold PC so z is updated before the skip decision.
                            Op      = 3'b011;
                            wez     = 1'b1;
                            pc_en   = 1'b0;
                            retire  = 1'b0;
                            state_d = ST_SKIP;
                        end
                        3'b111: begin
                            s_inc   = 1'b0;
                            pc_en   = 1'b0;
                            retire  = 1'b0;
                            state_d = ST_HALT;
                        end
                        default: ;
                    endcase
                end
                ST_SKIP: begin
                    s_inc   = 1'b1;
                    s_skip  = z;
                    pc_en   = 1'b1;
                    retire  = 1'b1;
                    state_d = ST_RUN;
                end
                ST_HALT: halted = 1'b1;
                default: state_d = ST_RUN;
            endcase

            if (retire && (count_q != C_CNT_MAX)) begin
                count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_uc_multiciclo.sv
`default_nettype none
// Directed bench for uc_multiciclo: per-cycle comparison against a behavioural
// model plus literal spot checks. A narrow counter exercises saturation.
module tb_uc_multiciclo;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [5:0]       Opcode = 6'b010000;
    logic             z = 1'b0;
    logic             s_inc, s_inm, s_skip, we3, wez, pc_en, halted;
    logic [2:0]       Op;
    logic [CNT_W-1:0] instr_count;

    int errors = 0;
    int checks = 0;

    uc_multiciclo #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .z(z),
        .s_inc(s_inc), .s_inm(s_inm), .s_skip(s_skip), .we3(we3), .wez(wez),
        .Op(Op), .pc_en(pc_en), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Model: skipeq leaves a pending skip decision; halt stops everything.
    bit m_pend  = 1'b0;
    bit m_stop  = 1'b0;
    int m_count = 0;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Packed as {s_inc, s_inm, s_skip, we3, wez, Op, pc_en, halted}
    function automatic logic [9:0] model_out(input logic r, input bit pend, input bit stop,
                                             input logic [5:0] opc, input logic zz);
        logic inc, inm, skp, w3, wz, pe, hl;
        logic [2:0] alu;
        {inc, inm, skp, w3, wz, alu, pe, hl} = '0;
        if (!r) begin
            // everything zero
        end else if (stop) begin
            hl = 1'b1;
        end else if (pend) begin
            inc = 1'b1; skp = zz; pe = 1'b1;
        end else begin
            inc = 1'b1; pe = 1'b1;
            if (opc[5:3] == 3'd0) begin alu = opc[2:0]; w3 = 1'b1; wz = 1'b1; end
            if (opc[5:3] == 3'd1) begin inm = 1'b1; w3 = 1'b1; end
            if (opc[5:3] == 3'd2) inc = 1'b0;
            if (opc[5:3] == 3'd3) inc = ~zz;
            if (opc[5:3] == 3'd4) inc = zz;
            if (opc[5:3] == 3'd5) begin alu = 3'b011; wz = 1'b1; pe = 1'b0; end
            if (opc[5:3] == 3'd7) begin inc = 1'b0; pe = 1'b0; end
        end
        return {inc, inm, skp, w3, wz, alu, pe, hl};
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_pend <= 1'b0; m_stop <= 1'b0; m_count <= 0;
        end else if (m_stop) begin
            m_stop <= 1'b1;
        end else if (m_pend) begin
            m_pend <= 1'b0; m_count <= sat(m_count + 1);
        end else if (Opcode[5:3] == 3'd5) begin
            m_pend <= 1'b1;
        end else if (Opcode[5:3] == 3'd7) begin
            m_stop <= 1'b1;
        end else begin
            m_count <= sat(m_count + 1);
        end
    end

    always @(negedge clk) begin
        logic [9:0] exp_v, act_v;
        exp_v = model_out(reset, m_pend, m_stop, Opcode, z);
        act_v = {s_inc, s_inm, s_skip, we3, wez, Op, pc_en, halted};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model_outputs t=%0t op=%b z=%b actual=%b required=%b",
                     $time, Opcode, z, act_v, exp_v);
        end
        checks++;
        if (instr_count !== CNT_W'(m_count)) begin
            errors++;
            $display("FAIL model_count t=%0t actual=%0d required=%0d",
                     $time, instr_count, m_count);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic step(input logic r, input logic [5:0] opc, input logic zz);
        @(posedge clk);
        #1;
        reset = r; Opcode = opc; z = zz;
        @(negedge clk);
        #1;
    endtask

    initial begin
        step(1'b0, 6'b010000, 1'b0);
        step(1'b0, 6'b010000, 1'b0);
        chk("reset_outs", {s_inc, s_inm, s_skip, we3, wez, Op, pc_en, halted}, 32'h0);
        chk("reset_count", instr_count, 0);

        step(1'b1, 6'b010000, 1'b0);
        chk("jmp_s_inc", s_inc, 0);
        chk("jmp_pc_en", pc_en, 1);
        step(1'b0, 6'b010000, 1'b0);
        chk("jmp_retired", instr_count, 1);

        step(1'b1, 6'b001000, 1'b0);
        chk("li_ctrl", {s_inm, we3, wez}, 32'b110);
        step(1'b1, 6'b000010, 1'b0);
        chk("alu2_ctrl", {Op, we3, wez}, 32'b01011);
        step(1'b1, 6'b000011, 1'b0);
        chk("alu3_op", Op, 3'b011);
        step(1'b1, 6'b110000, 1'b0);
        chk("count_after_three", instr_count, 3);

        step(1'b1, 6'b101000, 1'b0);
        chk("skipeq_cmp", {Op, wez, we3, pc_en}, 32'b011100);
        step(1'b1, 6'b101000, 1'b1);
        chk("skip_eq", {s_skip, s_inc, pc_en, Op}, 32'b111000);
        chk("count_cmp_not_counted", instr_count, 4);
        step(1'b1, 6'b110000, 1'b0);
        chk("skip_counted", instr_count, 5);

        step(1'b1, 6'b101000, 1'b0);
        step(1'b1, 6'b101000, 1'b0);
        chk("skip_ne", {s_skip, s_inc, pc_en}, 32'b011);

        step(1'b1, 6'b101000, 1'b1);
        step(1'b1, 6'b101000, 1'b1);
        step(1'b1, 6'b101000, 1'b0);
        chk("b2b_second_cmp", {wez, pc_en, s_skip}, 32'b100);
        step(1'b1, 6'b101000, 1'b0);

        step(1'b1, 6'b011000, 1'b1); chk("jz_taken", s_inc, 0);
        step(1'b1, 6'b011000, 1'b0); chk("jz_not", s_inc, 1);
        step(1'b1, 6'b100000, 1'b1); chk("jnz_not", s_inc, 1);
        step(1'b1, 6'b100000, 1'b0); chk("jnz_taken", s_inc, 0);

        step(1'b1, 6'b111000, 1'b0);
        chk("halt_decode", {pc_en, halted}, 32'b00);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 6'(8 * i + 3), 1'(i));
            chk("halted_hold", {halted, pc_en, we3}, 32'b100);
        end
        chk("halt_count", instr_count, 13);

        step(1'b0, 6'b000001, 1'b0);
        step(1'b1, 6'b110000, 1'b0);
        chk("unhalt", {halted, pc_en}, 32'b01);
        chk("unhalt_count", instr_count, 0);

        step(1'b1, 6'b101000, 1'b1);
        step(1'b0, 6'b101000, 1'b1);
        chk("reset_in_skip", {s_skip, pc_en}, 32'b00);
        step(1'b1, 6'b110000, 1'b1);
        chk("after_skip_reset", {s_skip, pc_en, s_inc}, 32'b011);

        for (int i = 0; i < 20; i++) step(1'b1, 6'b110000, 1'b0);
        chk("saturated", instr_count, CMAX);

        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
